bus_controller: RTL and testbench

Multi-cycle control sequencer for the 8-bit RISC CPU. It fetches an instruction byte, decodes it, and steps through execution. On every cycle it drives the 3-bit source select of the shared 8-bit bus multiplexer, along with the destination load enables and memory strobes. It sits directly upstream of the bus mux: its `selectors` output is the mux select input.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/bus_controller_ctrl_decode.sv | 103 ++++++++++
 rtl/bus_controller.sv | 101 ++++++++++
 tb/tb_bus_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit RISC CPU control path.
// Holds bus source codes, opcodes and the control-sequencer state encoding.
// Used by bus_controller, ctrl_decode, the bus mux and the datapath.
package cpu_pkg;

  // Bus sources (mux select values)
  localparam logic [2:0] SRC_PC  = 3'd0;
  localparam logic [2:0] SRC_MDR = 3'd1;
  localparam logic [2:0] SRC_ALU = 3'd2;
  localparam logic [2:0] SRC_ACC = 3'd3;
  localparam logic [2:0] SRC_R0  = 3'd4;
  localparam logic [2:0] SRC_R1  = 3'd5;
  localparam logic [2:0] SRC_R2  = 3'd6;
  localparam logic [2:0] SRC_R3  = 3'd7;

  // Opcodes (ir[7:5])
  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_MOV_AR  = 3'b001;  // ACC <- Rr
  localparam logic [2:0] OP_MOV_RA  = 3'b010;  // Rr <- ACC
  localparam logic [2:0] OP_ADD     = 3'b011;
  localparam logic [2:0] OP_SUB     = 3'b100;
  localparam logic [2:0] OP_LDI     = 3'b101;
  localparam logic [2:0] OP_JMP     = 3'b110;
  localparam logic [2:0] OP_HLT     = 3'b111;

  // Sequencer states, binary encoded
  typedef enum logic [2:0] {
    ST_F0   = 3'd0,
    ST_F1   = 3'd1,
    ST_F2   = 3'd2,
    ST_DEC  = 3'd3,
    ST_X1   = 3'd4,
    ST_X2   = 3'd5,
    ST_X3   = 3'd6,
    ST_HALT = 3'd7
  } state_t;

endpackage

// File: rtl/bus_controller_ctrl_decode.sv
// ctrl_decode: combinational decoder from sequencer state + instruction
// register to the control word (bus select, load enables, strobes).
// Ports:
//   state      in  3  current sequencer state (cpu_pkg::state_t encoding)
//   ir         in  8  instruction register, opcode ir[7:5], reg field ir[1:0]
//   selectors  out 3  bus source select
//   load_*     out    destination load enables, load_r one-hot per register
//   pc_inc, mem_read, alu_op, halted  out 1 each
import cpu_pkg::*;

module ctrl_decode (
  input  logic [2:0] state,
  input  logic [7:0] ir,
  output logic [2:0] selectors,
  output logic       load_mar,
  output logic       load_ir,
  output logic       load_pc,
  output logic       load_acc,
  output logic       load_tmp,
  output logic [3:0] load_r,
  output logic       pc_inc,
  output logic       mem_read,
  output logic       alu_op,
  output logic       halted
);

  state_t     st;
  logic [2:0] opcode;
  logic [1:0] rsel;

  assign st     = state_t'(state);
  assign opcode = ir[7:5];
  assign rsel   = ir[1:0];

  always_comb begin
    selectors = SRC_PC;
    load_mar  = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    load_acc  = 1'b0;
    load_tmp  = 1'b0;
    load_r    = 4'b0000;
    pc_inc    = 1'b0;
    mem_read  = 1'b0;
    alu_op    = 1'b0;
    halted    = 1'b0;
    case (st)
      ST_F0: load_mar = 1'b1;
      ST_F1: mem_read = 1'b1;
      ST_F2: begin
        selectors = SRC_MDR;
        load_ir   = 1'b1;
        pc_inc    = 1'b1;
      end
      ST_X1: begin
        case (opcode)
          OP_MOV_AR: begin
            selectors = {1'b1, rsel};
            load_acc  = 1'b1;
          end
          OP_MOV_RA: begin
            selectors = SRC_ACC;
            load_r    = 4'(4'b0001 << rsel);
          end
          OP_ADD, OP_SUB: begin
            selectors = {1'b1, rsel};
            load_tmp  = 1'b1;
          end
          OP_LDI, OP_JMP: load_mar = 1'b1;
          default: ;
        endcase
      end
      ST_X2: begin
        case (opcode)
          OP_ADD, OP_SUB: begin
            selectors = SRC_ALU;
            alu_op    = opcode[2];  // 011 -> add, 100 -> subtract
            load_acc  = 1'b1;
          end
          OP_LDI, OP_JMP: mem_read = 1'b1;
          default: ;
        endcase
      end
      ST_X3: begin
        case (opcode)
          OP_LDI: begin
            selectors = SRC_MDR;
            load_acc  = 1'b1;
            pc_inc    = 1'b1;  // step over the immediate byte
          end
          OP_JMP: begin
            selectors = SRC_MDR;
            load_pc   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_controller.sv
// bus_controller: multi-cycle control sequencer for the 8-bit RISC CPU.
// Keeps the state register and next-state logic; ctrl_decode turns the state
// and ir into the Moore control word. All outputs are forced low while reset
// is high, so the F0 control word only appears once reset is released.
// Ports:
//   clk, reset (async, active-high), ir[7:0], mem_ready
//   selectors[2:0] bus mux select; load_mar/ir/pc/acc/tmp, load_r[3:0];
//   pc_inc, mem_read, alu_op, halted
import cpu_pkg::*;

module bus_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic       mem_ready,
  output logic [2:0] selectors,
  output logic       load_mar,
  output logic       load_ir,
  output logic       load_pc,
  output logic       load_acc,
  output logic       load_tmp,
  output logic [3:0] load_r,
  output logic       pc_inc,
  output logic       mem_read,
  output logic       alu_op,
  output logic       halted
);

  state_t     state_q, state_d;
  logic [2:0] opcode;

  logic [2:0] dec_sel;
  logic       dec_mar, dec_ir, dec_pc, dec_acc, dec_tmp;
  logic [3:0] dec_r;
  logic       dec_inc, dec_rd, dec_op, dec_halt;

  assign opcode = ir[7:5];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_F0:  state_d = ST_F1;
      ST_F1:  if (mem_ready) state_d = ST_F2;
      ST_F2:  state_d = ST_DEC;
      ST_DEC: begin
        if (opcode == OP_NOP)      state_d = ST_F0;
        else if (opcode == OP_HLT) state_d = ST_HALT;
        else                       state_d = ST_X1;
      end
      ST_X1: begin
        if (opcode == OP_MOV_AR || opcode == OP_MOV_RA) state_d = ST_F0;
        else                                           state_d = ST_X2;
      end
      ST_X2: begin
        if (opcode == OP_LDI || opcode == OP_JMP) begin
          if (mem_ready) state_d = ST_X3;
        end else begin
          state_d = ST_F0;
        end
      end
      ST_X3:   state_d = ST_F0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_F0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_F0;
    else       state_q <= state_d;
  end

  ctrl_decode u_ctrl_decode (
    .state     (state_q),
    .ir        (ir),
    .selectors (dec_sel),
    .load_mar  (dec_mar),
    .load_ir   (dec_ir),
    .load_pc   (dec_pc),
    .load_acc  (dec_acc),
    .load_tmp  (dec_tmp),
    .load_r    (dec_r),
    .pc_inc    (dec_inc),
    .mem_read  (dec_rd),
    .alu_op    (dec_op),
    .halted    (dec_halt)
  );

  // Gate with reset so an aborted instruction issues no load in the reset cycle.
  assign selectors = reset ? 3'b000  : dec_sel;
  assign load_mar  = ~reset & dec_mar;
  assign load_ir   = ~reset & dec_ir;
  assign load_pc   = ~reset & dec_pc;
  assign load_acc  = ~reset & dec_acc;
  assign load_tmp  = ~reset & dec_tmp;
  assign load_r    = reset ? 4'b0000 : dec_r;
  assign pc_inc    = ~reset & dec_inc;
  assign mem_read  = ~reset & dec_rd;
  assign alu_op    = ~reset & dec_op;
  assign halted    = ~reset & dec_halt;

endmodule

// File: tb/tb_bus_controller.sv
module tb_bus_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ir;
  logic       mem_ready;
  logic [2:0] selectors;
  logic       load_mar, load_ir, load_pc, load_acc, load_tmp;
  logic [3:0] load_r;
  logic       pc_inc, mem_read, alu_op, halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_controller dut (
    .clk(clk), .reset(reset), .ir(ir), .mem_ready(mem_ready),
    .selectors(selectors), .load_mar(load_mar), .load_ir(load_ir),
    .load_pc(load_pc), .load_acc(load_acc), .load_tmp(load_tmp),
    .load_r(load_r), .pc_inc(pc_inc), .mem_read(mem_read),
    .alu_op(alu_op), .halted(halted)
  );

  // Word layout: {sel[2:0], mar, ir, pc, acc, tmp, r[3:0], inc, rd, op, hlt}
  logic [15:0] dut_w;
  assign dut_w = {selectors, load_mar, load_ir, load_pc, load_acc, load_tmp,
                  load_r, pc_inc, mem_read, alu_op, halted};

  function automatic logic [15:0] mk(input logic [2:0] sel, input logic [4:0] lds,
                                     input logic [3:0] r, input logic inc,
                                     input logic rd, input logic op, input logic hlt);
    return {sel, lds, r, inc, rd, op, hlt};
  endfunction

  // lds bit order: mar, ir, pc, acc, tmp
  localparam logic [4:0] L_MAR = 5'b10000, L_IR = 5'b01000, L_PC = 5'b00100,
                         L_ACC = 5'b00010, L_TMP = 5'b00001;

  logic [15:0] w_f0, w_f1, w_f2, w_dec, w_halt;

  typedef struct {
    logic [7:0]  ir;
    int          f1_waits;
    int          lo_start;   // first cycle (from F0) with mem_ready low
    int          lo_n;       // number of low cycles
    int          nx;
    logic [15:0] x [6];
    string       name;
  } vec_t;

  vec_t        vecs [10];
  int          nvec = 0;
  logic [15:0] exp_q [$];

  task automatic add_vec(input logic [7:0] i, input int f1w, input int los, input int lon,
                         input int n, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d,
                         input logic [15:0] e, input logic [15:0] f, input string nm);
    vecs[nvec].ir = i; vecs[nvec].f1_waits = f1w;
    vecs[nvec].lo_start = los; vecs[nvec].lo_n = lon; vecs[nvec].nx = n;
    vecs[nvec].x[0] = a; vecs[nvec].x[1] = b; vecs[nvec].x[2] = c;
    vecs[nvec].x[3] = d; vecs[nvec].x[4] = e; vecs[nvec].x[5] = f;
    vecs[nvec].name = nm;
    nvec++;
  endtask

  task automatic check(input string nm, input int cyc, input logic [15:0] exp);
    checks++;
    if (dut_w !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h exp %h", nm, cyc, dut_w, exp);
    end
  endtask

  // Push the fetch/decode words for an instruction into the scoreboard.
  task automatic push_fetch(input int f1w);
    exp_q.push_back(w_f0);
    for (int k = 0; k <= f1w; k++) exp_q.push_back(w_f1);
    exp_q.push_back(w_f2);
    exp_q.push_back(w_dec);
  endtask

  // Drain up to max_cyc scoreboard entries, one per clock; entered just after a negedge.
  task automatic drain(input logic [7:0] i, input int los, input int lon,
                       input int max_cyc, input string nm);
    int c = 0;
    logic [15:0] e;
    ir = i;
    while (exp_q.size() > 0 && c < max_cyc) begin
      mem_ready = (lon > 0 && c >= los && c < los + lon) ? 1'b0 : 1'b1;
      #1;
      e = exp_q.pop_front();
      check(nm, c, e);
      c++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input int v);
    push_fetch(vecs[v].f1_waits);
    for (int k = 0; k < vecs[v].nx; k++) exp_q.push_back(vecs[v].x[k]);
    drain(vecs[v].ir, vecs[v].lo_start, vecs[v].lo_n, 64, vecs[v].name);
  endtask

  initial begin
    w_f0   = mk(3'd0, L_MAR, 4'b0, 0, 0, 0, 0);
    w_f1   = mk(3'd0, 5'b0,  4'b0, 0, 1, 0, 0);
    w_f2   = mk(3'd1, L_IR,  4'b0, 1, 0, 0, 0);
    w_dec  = 16'h0000;
    w_halt = mk(3'd0, 5'b0,  4'b0, 0, 0, 0, 1);

    add_vec(8'b000_000_00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "nop");
    add_vec(8'b000_000_00, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, "nop_f1wait");
    add_vec(8'b001_000_01, 0, 0, 0, 1, mk(3'd5, L_ACC, 0, 0, 0, 0, 0),
            0, 0, 0, 0, 0, "mov_acc_r1");
    add_vec(8'b010_000_11, 0, 0, 0, 1, mk(3'd3, 0, 4'b1000, 0, 0, 0, 0),
            0, 0, 0, 0, 0, "mov_r3_acc");
    add_vec(8'b011_000_10, 0, 0, 0, 2, mk(3'd6, L_TMP, 0, 0, 0, 0, 0),
            mk(3'd2, L_ACC, 0, 0, 0, 0, 0), 0, 0, 0, 0, "add_r2");
    add_vec(8'b100_000_01, 0, 3, 3, 2, mk(3'd5, L_TMP, 0, 0, 0, 0, 0),
            mk(3'd2, L_ACC, 0, 0, 0, 1, 0), 0, 0, 0, 0, "sub_r1_rdy_ignored");
    add_vec(8'b101_000_00, 0, 5, 3, 6, mk(3'd0, L_MAR, 0, 0, 0, 0, 0),
            w_f1, w_f1, w_f1, w_f1, mk(3'd1, L_ACC, 0, 1, 0, 0, 0), "ldi_wait3");
    add_vec(8'b110_000_00, 0, 0, 0, 3, mk(3'd0, L_MAR, 0, 0, 0, 0, 0),
            w_f1, mk(3'd1, L_PC, 0, 0, 0, 0, 0), 0, 0, 0, "jmp");
    add_vec(8'b001_111_00, 0, 0, 0, 1, mk(3'd4, L_ACC, 0, 0, 0, 0, 0),
            0, 0, 0, 0, 0, "mov_acc_r0_midbits");
    add_vec(8'b010_101_00, 0, 0, 0, 1, mk(3'd3, 0, 4'b0001, 0, 0, 0, 0),
            0, 0, 0, 0, 0, "mov_r0_acc");

    reset = 1'b1; ir = 8'h00; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", 0, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < nvec; v++) run_vec(v);

    // Reset during X2 of ADD: outputs drop to 0 in that cycle, then restart at F0.
    push_fetch(0);
    exp_q.push_back(mk(3'd6, L_TMP, 0, 0, 0, 0, 0));
    drain(8'b011_000_10, 0, 0, 64, "add_pre_reset");
    reset = 1'b1;
    #1 check("reset_in_x2", 0, 16'h0000);
    @(negedge clk);
    #1 check("reset_in_x2_hold", 1, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    run_vec(0);

    // HLT: absorbing for 20 cycles regardless of mem_ready.
    push_fetch(0);
    drain(8'b111_000_00, 0, 0, 64, "hlt_fetch");
    for (int k = 0; k < 20; k++) begin
      mem_ready = 1'($urandom_range(0, 1));
      exp_q.push_back(w_halt);
      #1 check("halted", k, exp_q.pop_front());
      @(negedge clk);
    end
    reset = 1'b1;
    #1 check("reset_from_halt", 0, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    run_vec(4);
    run_vec(0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_left got %0d entries exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
